// File: rtl/nbled_monitor.sv
// nbled_monitor: locks onto the 37-step flowing-light LED sequence and checks every strobed sample
// against the predicted next pattern, counting mismatches and completed cycles.
module nbled_monitor #(
    parameter int ERR_W = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [11:0]      led_in,
    input  logic             led_vld,
    output logic [2:0]       phase,
    output logic             locked,
    output logic             err,
    output logic [ERR_W-1:0] err_cnt,
    output logic [CNT_W-1:0] seq_cnt,
    output logic [11:0]      expected
);
    typedef enum logic {HUNT, LOCK} state_t;
    state_t      state, state_nx;
    logic [2:0]  exp_ph, exp_ph_nx, ph_nx, succ_ph;
    logic [11:0] exp_nx, succ;
    logic        err_nx, inc_err, inc_seq;
    logic [5:0]  h, l;
    assign h = expected[11:6];
    assign l = expected[5:0];
    assign locked = (state == LOCK);
    // successor of the pattern currently predicted; exp_ph is that pattern's phase
    always_comb begin
        succ    = 12'h000;
        succ_ph = exp_ph;
        if (expected == 12'h000) begin
            succ    = 12'h001;
            succ_ph = 3'd1;
        end else if (expected == 12'hFFF) begin
            succ_ph = (exp_ph == 3'd4) ? 3'd0 : exp_ph + 3'd1;
            succ    = (exp_ph == 3'd1) ? 12'h800 :
                      (exp_ph == 3'd2) ? 12'h801 :
                      (exp_ph == 3'd3) ? 12'h060 : 12'h000;
        end else begin
            succ = (exp_ph == 3'd1) ? {expected[10:0], 1'b1} :
                   (exp_ph == 3'd2) ? {1'b1, expected[11:1]} :
                   (exp_ph == 3'd3) ? {1'b1, h[5:1], l[4:0], 1'b1} :
                                      {h[4:0], 1'b1, 1'b1, l[5:1]};
        end
    end
    always_comb begin
        state_nx  = state;
        ph_nx     = phase;
        exp_nx    = expected;
        exp_ph_nx = exp_ph;
        err_nx    = 1'b0;
        inc_err   = 1'b0;
        inc_seq   = 1'b0;
        if (led_vld) begin
            if (state == HUNT) begin
                if (led_in == 12'h000) begin
                    state_nx  = LOCK;
                    ph_nx     = 3'd0;
                    exp_nx    = 12'h001;
                    exp_ph_nx = 3'd1;
                end
            end else if (led_in == expected) begin
                ph_nx     = exp_ph;
                exp_nx    = succ;
                exp_ph_nx = succ_ph;
                inc_seq   = (exp_ph == 3'd0);
            end else begin
                err_nx  = 1'b1;
                inc_err = 1'b1;
                if (led_in == 12'h000) begin
                    ph_nx     = 3'd0;
                    exp_nx    = 12'h001;
                    exp_ph_nx = 3'd1;
                end else begin
                    state_nx  = HUNT;
                    exp_nx    = 12'h000;
                    exp_ph_nx = 3'd0;
                end
            end
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= HUNT;
            phase    <= 3'd0;
            exp_ph   <= 3'd0;
            expected <= 12'h000;
            err      <= 1'b0;
            err_cnt  <= '0;
            seq_cnt  <= '0;
        end else begin
            state    <= state_nx;
            phase    <= ph_nx;
            exp_ph   <= exp_ph_nx;
            expected <= exp_nx;
            err      <= err_nx;
            if (inc_err && !(&err_cnt)) err_cnt <= err_cnt + 1'b1;
            if (inc_seq) seq_cnt <= seq_cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_nbled_monitor.sv
// tb_nbled_monitor: directed checks of nbled_monitor against the hand-written 37-step LED sequence.
module tb_nbled_monitor;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [11:0] led_in = 12'h000;
    logic        led_vld = 1'b0;
    logic [2:0]  phase;
    logic        locked, err;
    logic [7:0]  err_cnt;
    logic [15:0] seq_cnt;
    logic [11:0] expected;
    int vectors = 0;
    int miscompares = 0;

    logic [11:0] seq_t [0:36] = '{
        12'h000,
        12'h001, 12'h003, 12'h007, 12'h00F, 12'h01F, 12'h03F, 12'h07F, 12'h0FF, 12'h1FF, 12'h3FF, 12'h7FF, 12'hFFF,
        12'h800, 12'hC00, 12'hE00, 12'hF00, 12'hF80, 12'hFC0, 12'hFE0, 12'hFF0, 12'hFF8, 12'hFFC, 12'hFFE, 12'hFFF,
        12'h801, 12'hC03, 12'hE07, 12'hF0F, 12'hF9F, 12'hFFF,
        12'h060, 12'h0F0, 12'h1F8, 12'h3FC, 12'h7FE, 12'hFFF};

    nbled_monitor #(.ERR_W(8), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .led_in(led_in), .led_vld(led_vld),
        .phase(phase), .locked(locked), .err(err), .err_cnt(err_cnt),
        .seq_cnt(seq_cnt), .expected(expected));

    always #5 clk = ~clk;

    function automatic logic [2:0] ph_of(input int i);
        return (i == 0) ? 3'd0 : (i <= 12) ? 3'd1 : (i <= 24) ? 3'd2 : (i <= 30) ? 3'd3 : 3'd4;
    endfunction

    // inputs change on the falling edge; outputs are read on the following falling edge
    task automatic step(input logic [11:0] v);
        @(negedge clk);
        led_in = v;
        led_vld = 1'b1;
        @(negedge clk);
        led_vld = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        led_vld = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        vectors++;
        if ({phase, locked, err, err_cnt, seq_cnt, expected} !== 42'd0) begin
            miscompares++;
            $display("FAIL reset: got phase=%0d locked=%b err=%b err_cnt=%h seq_cnt=%h expected=%h, want all 0",
                     phase, locked, err, err_cnt, seq_cnt, expected);
        end
    endtask

    task automatic test_full_cycle();
        do_reset();
        for (int i = 0; i <= 37; i++) begin
            step(seq_t[i % 37]);
            vectors++;
            if ({locked, err, phase, expected, seq_cnt} !== {1'b1, 1'b0, ph_of(i % 37), seq_t[(i + 1) % 37], (i == 37) ? 16'd1 : 16'd0}) begin
                miscompares++;
                $display("FAIL full_cycle[%0d]: got locked=%b err=%b phase=%0d expected=%h seq_cnt=%0d, want 1 0 %0d %h %0d",
                         i, locked, err, phase, expected, seq_cnt, ph_of(i % 37), seq_t[(i + 1) % 37], (i == 37) ? 1 : 0);
            end
        end
        step(12'h555);
        vectors++;
        if ({locked, err, seq_cnt} !== {1'b0, 1'b1, 16'd1}) begin
            miscompares++;
            $display("FAIL seq_cnt_kept: got locked=%b err=%b seq_cnt=%0d, want 0 1 1", locked, err, seq_cnt);
        end
    endtask

    task automatic test_fill_r_mismatch();
        do_reset();
        for (int i = 0; i <= 14; i++) step(seq_t[i]);
        step(12'h700);
        vectors++;
        if ({err, err_cnt, locked, expected, phase} !== {1'b1, 8'd1, 1'b0, 12'h000, 3'd2}) begin
            miscompares++;
            $display("FAIL fill_r_mismatch: got err=%b err_cnt=%0d locked=%b expected=%h phase=%0d, want 1 1 0 000 2",
                     err, err_cnt, locked, expected, phase);
        end
        @(negedge clk);
        vectors++;
        if (err !== 1'b0) begin
            miscompares++;
            $display("FAIL err_one_cycle: got err=%b, want 0", err);
        end
        step(12'h001);
        step(12'h003);
        vectors++;
        if ({err, err_cnt, locked, expected} !== {1'b0, 8'd1, 1'b0, 12'h000}) begin
            miscompares++;
            $display("FAIL hunt_ignore: got err=%b err_cnt=%0d locked=%b expected=%h, want 0 1 0 000",
                     err, err_cnt, locked, expected);
        end
    endtask

    task automatic test_in_restart();
        do_reset();
        for (int i = 0; i <= 27; i++) step(seq_t[i]);
        step(12'h000);
        vectors++;
        if ({err, err_cnt, locked, phase, expected} !== {1'b1, 8'd1, 1'b1, 3'd0, 12'h001}) begin
            miscompares++;
            $display("FAIL in_restart: got err=%b err_cnt=%0d locked=%b phase=%0d expected=%h, want 1 1 1 0 001",
                     err, err_cnt, locked, phase, expected);
        end
        step(12'h001);
        vectors++;
        if ({err, err_cnt, locked, phase, expected} !== {1'b0, 8'd1, 1'b1, 3'd1, 12'h003}) begin
            miscompares++;
            $display("FAIL in_restart_accept: got err=%b err_cnt=%0d locked=%b phase=%0d expected=%h, want 0 1 1 1 003",
                     err, err_cnt, locked, phase, expected);
        end
    endtask

    task automatic test_fff_successors();
        logic [11:0] want [3] = '{12'h800, 12'h801, 12'h060};
        int          idx  [3] = '{12, 24, 30};
        int          k = 0;
        do_reset();
        for (int i = 0; i <= 30; i++) begin
            step(seq_t[i]);
            if (k < 3 && i == idx[k]) begin
                vectors++;
                if ({expected, phase} !== {want[k], 3'(k + 1)}) begin
                    miscompares++;
                    $display("FAIL fff_succ[%0d]: got expected=%h phase=%0d, want %h %0d", k, expected, phase, want[k], k + 1);
                end
                k++;
            end
        end
    endtask

    task automatic test_saturation();
        do_reset();
        step(12'h000);
        for (int p = 1; p <= 256; p++) begin
            step(12'h555);
            step(12'h000);
            if (p == 254) begin
                vectors++;
                if (err_cnt !== 8'hFE) begin
                    miscompares++;
                    $display("FAIL err_cnt_254: got %h, want fe", err_cnt);
                end
            end
        end
        vectors++;
        if ({err_cnt, locked, err} !== {8'hFF, 1'b1, 1'b0}) begin
            miscompares++;
            $display("FAIL err_cnt_256: got err_cnt=%h locked=%b err=%b, want ff 1 0", err_cnt, locked, err);
        end
        step(12'h555);
        vectors++;
        if ({err_cnt, err} !== {8'hFF, 1'b1}) begin
            miscompares++;
            $display("FAIL err_cnt_sat: got err_cnt=%h err=%b, want ff 1", err_cnt, err);
        end
    endtask

    task automatic test_hold_and_rst();
        do_reset();
        for (int i = 0; i <= 33; i++) step(seq_t[i]);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            led_in = 12'($urandom);
            vectors++;
            if ({phase, locked, err, err_cnt, seq_cnt, expected} !== {3'd4, 1'b1, 1'b0, 8'd0, 16'd0, 12'h3FC}) begin
                miscompares++;
                $display("FAIL hold[%0d]: got phase=%0d locked=%b err=%b err_cnt=%h seq_cnt=%h expected=%h, want 4 1 0 00 0000 3fc",
                         c, phase, locked, err, err_cnt, seq_cnt, expected);
            end
        end
        @(negedge clk);
        led_in = 12'h3FC;
        led_vld = 1'b1;
        rst = 1'b1;
        @(negedge clk);
        led_vld = 1'b0;
        rst = 1'b0;
        vectors++;
        if ({phase, locked, err, err_cnt, seq_cnt, expected} !== 42'd0) begin
            miscompares++;
            $display("FAIL rst_wins: got phase=%0d locked=%b err=%b err_cnt=%h seq_cnt=%h expected=%h, want all 0",
                     phase, locked, err, err_cnt, seq_cnt, expected);
        end
    endtask

    initial begin
        test_reset();
        test_full_cycle();
        test_fill_r_mismatch();
        test_in_restart();
        test_fff_successors();
        test_saturation();
        test_hold_and_rst();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
